zx_tape_player: RTL and testbench
=================================

ZX_TAPE_PLAYER -- requirements
Module: zx_tape_player

Interface
REQ-001 Parameter PULSE_CYC, default 7800, SHALL set the clk_sys cycles per pulse half-period (150 us at 52 MHz).
REQ-002 Parameter GAP_CYC, default 67600, SHALL set the clk_sys cycles of silence after each bit (1300 us).
REQ-003 Parameter LEADER_CYC, default 26000000, SHALL set the clk_sys cycles of leading silence (0.5 s).
REQ-004 clk_sys  in  1  system clock (52 MHz).
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to begin playback.
REQ-007 stop  in  1  abort playback.
REQ-008 add_name  in  1  emit a synthetic name byte 0x80 before the image data (ZX81 .p images).
REQ-009 length  in  14  number of image bytes, sampled on accepted start.
REQ-010 rd_addr  out  14  tape RAM byte address.
REQ-011 rd_data  in  8  tape RAM data, valid exactly 1 cycle after rd_addr changes.
REQ-012 tape_out  out  1  tape level (1 = pulse high), drives the CPU tape_in bit.
REQ-013 busy  out  1  playback in progress.
REQ-014 done  out  1  one-cycle pulse on normal completion.

Function
REQ-015 States SHALL be IDLE, LEADER, FETCH, LATCH, PULSE_HI, PULSE_LO, GAP and DONE.
REQ-016 IDLE + start SHALL latch length and add_name, clear byte index and rd_addr to 0, and enter LEADER; busy goes 1 on the next cycle.
REQ-017 LEADER SHALL hold tape_out=0 for LEADER_CYC cycles, then enter DONE if length==0 and add_name==0, else FETCH.
REQ-018 FETCH SHALL present rd_addr = byte index, and LATCH SHALL load the shift register one cycle later (1-cycle RAM latency); when the name byte is pending, 0x80 SHALL be loaded instead and no RAM read is used.
REQ-019 Bits SHALL be sent MSB first; a 0 bit SHALL be 4 pulses and a 1 bit SHALL be 9 pulses.
REQ-020 Each pulse SHALL be PULSE_HI (tape_out=1, PULSE_CYC cycles) followed by PULSE_LO (tape_out=0, PULSE_CYC cycles).
REQ-021 After the last pulse of a bit, GAP SHALL hold tape_out=0 for GAP_CYC cycles.
REQ-022 After GAP: if bits remain, return to PULSE_HI with the next bit; otherwise advance to the next byte (FETCH), or enter DONE when the final byte has been sent.
REQ-023 The byte index SHALL be 14 bits; the name byte SHALL NOT advance it; bytes indices 0..length-1 SHALL be sent exactly once, with no wrap-around.
REQ-024 DONE SHALL assert done for exactly one cycle and return to IDLE; busy SHALL be 0 in IDLE.
REQ-025 start while busy SHALL be ignored.
REQ-026 stop SHALL take priority over start and over every state transition, forcing IDLE on the next cycle with tape_out=0, busy=0 and no done pulse.
REQ-027 Timing counters SHALL be wide enough for LEADER_CYC and SHALL reload on every state entry; total bit time SHALL be exact (no ±1 cycle drift).
REQ-028 tape_out SHALL be registered and glitch-free.

Reset
REQ-029 Reset SHALL force IDLE with tape_out=0, busy=0, done=0, rd_addr=0, and byte index, bit count and timers cleared.
REQ-030 Reset asserted mid-playback SHALL abort identically to stop, and a subsequent start SHALL restart from byte 0.

Verification
REQ-031 PULSE_CYC=2, GAP_CYC=5, LEADER_CYC=10; length=1, RAM[0]=0x80, add_name=0; start -> 10 low cycles, then 9 pulses (2 high / 2 low each), 5 gap cycles, then 7 groups of 4 pulses, then done once; tape_out high cycles total = 2*(9+28) = 74.
REQ-032 length=0, add_name=1 -> after the leader, byte 0x80 is emitted, no rd_addr change is used, then done.
REQ-033 length=3, RAM={0x00,0xFF,0xA5} -> rd_addr sequence 0,1,2, and the pulse counts per bit match the bit values MSB first.
REQ-034 stop asserted during the third pulse of byte 1 -> next cycle tape_out=0, busy=0, done never asserts; a new start replays from rd_addr=0.
REQ-035 start pulsed again while busy, and reset asserted mid-GAP -> the second start has no effect; reset yields IDLE outputs per REQ-029 on the next cycle.
REQ-036 length=0, add_name=0 -> done asserts exactly LEADER_CYC+1 cycles after start, and tape_out is never high.

Source files
------------

// File: rtl/zx_tape_player.sv
// Plays a byte image from tape RAM as ZX81-style pulse trains: a silent leader,
// then each bit MSB first as 4 (zero) or 9 (one) pulses followed by a silent gap.
module zx_tape_player #(
    parameter int unsigned PULSE_CYC  = 7800,
    parameter int unsigned GAP_CYC    = 67600,
    parameter int unsigned LEADER_CYC = 26000000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        add_name,
    input  logic [13:0] length,
    output logic [13:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        tape_out,
    output logic        busy,
    output logic        done
);

    localparam int unsigned MAX_AB  = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int unsigned MAX_CYC = (LEADER_CYC > MAX_AB) ? LEADER_CYC : MAX_AB;
    localparam int unsigned TW      = $clog2(MAX_CYC + 1);
    localparam int unsigned IW      = 14;

    localparam logic [TW-1:0] PULSE_RL  = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] GAP_RL    = TW'(GAP_CYC - 1);
    localparam logic [TW-1:0] LEADER_RL = TW'(LEADER_CYC - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LEADER   = 3'd1;
    localparam logic [2:0] S_FETCH    = 3'd2;
    localparam logic [2:0] S_LATCH    = 3'd3;
    localparam logic [2:0] S_PULSE_HI = 3'd4;
    localparam logic [2:0] S_PULSE_LO = 3'd5;
    localparam logic [2:0] S_GAP      = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    logic [2:0]    state,       state_n;
    logic [TW-1:0] timer,       timer_n;
    logic [IW-1:0] idx,         idx_n;
    logic [IW-1:0] len,         len_n;
    logic          name_pend,   name_n;
    logic [7:0]    shift,       shift_n;
    logic [2:0]    bits_left,   bits_n;
    logic [3:0]    pulses_left, pulses_n;
    logic [IW-1:0] rd_addr_n;
    logic          tape_n, busy_n, done_n;

    // State and output registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= S_IDLE;
            timer       <= '0;
            idx         <= '0;
            len         <= '0;
            name_pend   <= 1'b0;
            shift       <= '0;
            bits_left   <= '0;
            pulses_left <= '0;
            rd_addr     <= '0;
            tape_out    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            idx         <= idx_n;
            len         <= len_n;
            name_pend   <= name_n;
            shift       <= shift_n;
            bits_left   <= bits_n;
            pulses_left <= pulses_n;
            rd_addr     <= rd_addr_n;
            tape_out    <= tape_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they register cleanly
    always_comb begin
        state_n   = state;
        timer_n   = (timer != '0) ? timer - TW'(1) : timer;
        idx_n     = idx;
        len_n     = len;
        name_n    = name_pend;
        shift_n   = shift;
        bits_n    = bits_left;
        pulses_n  = pulses_left;
        rd_addr_n = rd_addr;

        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    state_n   = S_LEADER;
                    timer_n   = LEADER_RL;
                    len_n     = length;
                    name_n    = add_name;
                    idx_n     = '0;
                    rd_addr_n = '0;
                end
            end
            S_LEADER: begin
                if (timer == '0) begin
                    if (len == '0 && !name_pend) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_FETCH;
                        if (!name_pend) rd_addr_n = idx;
                    end
                end
            end
            S_FETCH: begin
                state_n = S_LATCH;
            end
            S_LATCH: begin
                shift_n  = name_pend ? 8'h80 : rd_data;
                bits_n   = 3'd7;
                pulses_n = shift_n[7] ? 4'd9 : 4'd4;
                state_n  = S_PULSE_HI;
                timer_n  = PULSE_RL;
            end
            S_PULSE_HI: begin
                if (timer == '0) begin
                    state_n = S_PULSE_LO;
                    timer_n = PULSE_RL;
                end
            end
            S_PULSE_LO: begin
                if (timer == '0) begin
                    if (pulses_left > 4'd1) begin
                        pulses_n = pulses_left - 4'd1;
                        state_n  = S_PULSE_HI;
                        timer_n  = PULSE_RL;
                    end else begin
                        state_n = S_GAP;
                        timer_n = GAP_RL;
                    end
                end
            end
            S_GAP: begin
                if (timer == '0) begin
                    if (bits_left != 3'd0) begin
                        bits_n   = bits_left - 3'd1;
                        shift_n  = {shift[6:0], 1'b0};
                        pulses_n = shift[6] ? 4'd9 : 4'd4;
                        state_n  = S_PULSE_HI;
                        timer_n  = PULSE_RL;
                    end else if (name_pend) begin
                        // Name byte does not consume an image index
                        name_n  = 1'b0;
                        state_n = (len == '0) ? S_DONE : S_FETCH;
                    end else if (idx == len - IW'(1)) begin
                        state_n = S_DONE;
                    end else begin
                        idx_n     = idx + IW'(1);
                        rd_addr_n = idx + IW'(1);
                        state_n   = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (stop) state_n = S_IDLE;

        tape_n = (state_n == S_PULSE_HI);
        busy_n = (state_n != S_IDLE);
        done_n = (state_n == S_DONE);
    end

endmodule

// File: tb/tb_zx_tape_player.sv
// Directed bench for zx_tape_player with short timing parameters; a negedge
// monitor decodes tape_out back into pulse groups, bits and bytes.
module tb_zx_tape_player;

    localparam int unsigned P = 2;
    localparam int unsigned G = 5;
    localparam int unsigned L = 10;

    logic        clk_sys = 1'b0;
    logic        reset, start, stop, add_name;
    logic [13:0] length;
    logic [13:0] rd_addr;
    logic [7:0]  rd_data;
    logic        tape_out, busy, done;

    logic [7:0]  ram [0:15];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mon_gen = 0;
    int seen_gen = 0;

    int high_cnt = 0, cur_pulses = 0, low_run = 0, hi_run = 0;
    int width_bad = 0, grp_bad = 0, done_cnt = 0, nbits = 0;
    logic       prev_tape = 1'b0;
    logic [7:0] shreg = 8'h00;
    logic [7:0]  bytes_q [$];
    logic [13:0] addr_q  [$];

    zx_tape_player #(.PULSE_CYC(P), .GAP_CYC(G), .LEADER_CYC(L)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .add_name (add_name),
        .length   (length),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .tape_out (tape_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_sys = ~clk_sys;

    // Tape RAM with one cycle of read latency
    always @(posedge clk_sys) rd_data <= ram[rd_addr[3:0]];

    // Decode tape_out into pulses, bits and bytes; log rd_addr values while busy
    always @(negedge clk_sys) begin
        if (mon_gen != seen_gen) begin
            seen_gen = mon_gen;
            high_cnt = 0; cur_pulses = 0; low_run = 0; hi_run = 0;
            width_bad = 0; grp_bad = 0; done_cnt = 0; nbits = 0;
            shreg = 8'h00;
            bytes_q.delete();
            addr_q.delete();
        end
        if (tape_out === 1'b1) begin
            if (prev_tape !== 1'b1) cur_pulses++;
            high_cnt++;
            hi_run++;
            low_run = 0;
        end else begin
            if (prev_tape === 1'b1 && hi_run != int'(P)) width_bad++;
            hi_run = 0;
            low_run++;
            if (low_run == int'(P) + 2 && cur_pulses != 0) begin
                if (cur_pulses != 9 && cur_pulses != 4) grp_bad++;
                shreg = {shreg[6:0], (cur_pulses == 9)};
                nbits++;
                if (nbits == 8) begin
                    bytes_q.push_back(shreg);
                    nbits = 0;
                end
                cur_pulses = 0;
            end
        end
        prev_tape = tape_out;
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1 && (addr_q.size() == 0 || addr_q[addr_q.size()-1] != rd_addr))
            addr_q.push_back(rd_addr);
    end

    task automatic step();
        @(negedge clk_sys);
        cyc++;
    endtask

    // Pulse start for one cycle; cyc=1 is the first sample after the accepting edge
    task automatic kick(input logic [13:0] len, input logic an);
        @(negedge clk_sys);
        length   = len;
        add_name = an;
        start    = 1'b1;
        mon_gen++;
        @(negedge clk_sys);
        start = 1'b0;
        cyc   = 1;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 3000; i++) begin
            if (done === 1'b1) begin
                lat = cyc;
                break;
            end
            step();
        end
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; add_name = 1'b0; length = '0;
        repeat (3) @(negedge clk_sys);
        total++; if (tape_out !== 1'b0) begin bad++; $display("FAIL reset_tape got=%b exp=0", tape_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (rd_addr !== 14'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", rd_addr); end
        reset = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic test_single_byte();
        int lat;
        ram[0] = 8'h80;
        kick(14'd1, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
        wait_done(lat);
        total++; if (lat !== 201) begin bad++; $display("FAIL single_latency got=%0d exp=201", lat); end
        total++; if (high_cnt !== 74) begin bad++; $display("FAIL single_high got=%0d exp=74", high_cnt); end
        total++; if (bytes_q.size() !== 1 || bytes_q[0] !== 8'h80) begin
            bad++; $display("FAIL single_byte got_n=%0d exp=1 byte0=%h exp=80", bytes_q.size(), bytes_q.size() > 0 ? bytes_q[0] : 8'hxx);
        end
        total++; if (width_bad !== 0 || grp_bad !== 0) begin
            bad++; $display("FAIL single_shape width_bad=%0d grp_bad=%0d exp=0", width_bad, grp_bad);
        end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL single_done_count got=%0d exp=1", done_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_name_only();
        int lat;
        kick(14'd0, 1'b1);
        wait_done(lat);
        total++; if (lat !== 201) begin bad++; $display("FAIL name_latency got=%0d exp=201", lat); end
        total++; if (bytes_q.size() !== 1 || bytes_q[0] !== 8'h80) begin
            bad++; $display("FAIL name_byte got_n=%0d exp=1 byte0=%h exp=80", bytes_q.size(), bytes_q.size() > 0 ? bytes_q[0] : 8'hxx);
        end
        total++; if (addr_q.size() !== 1 || addr_q[0] !== 14'd0) begin
            bad++; $display("FAIL name_addr got_n=%0d exp=1", addr_q.size());
        end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL name_done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic check_three(input string tag, input int lat);
        logic [23:0] got;
        logic [41:0] ag;
        got = 24'hxxxxxx;
        ag  = 42'hx;
        if (bytes_q.size() == 3) got = {bytes_q[0], bytes_q[1], bytes_q[2]};
        if (addr_q.size() == 3) ag = {addr_q[0], addr_q[1], addr_q[2]};
        total++; if (lat !== 761) begin bad++; $display("FAIL %s_latency got=%0d exp=761", tag, lat); end
        total++; if (got !== 24'h00FFA5) begin bad++; $display("FAIL %s_bytes got=%h exp=00ffa5 n=%0d", tag, got, bytes_q.size()); end
        total++; if (ag !== {14'd0, 14'd1, 14'd2}) begin bad++; $display("FAIL %s_addr_seq got=%h n=%0d exp=0,1,2", tag, ag, addr_q.size()); end
        total++; if (high_cnt !== 312) begin bad++; $display("FAIL %s_high got=%0d exp=312", tag, high_cnt); end
        total++; if (width_bad !== 0 || grp_bad !== 0) begin
            bad++; $display("FAIL %s_shape width_bad=%0d grp_bad=%0d exp=0", tag, width_bad, grp_bad);
        end
    endtask

    task automatic test_multi_byte();
        int lat;
        ram[0] = 8'h00; ram[1] = 8'hFF; ram[2] = 8'hA5;
        kick(14'd3, 1'b0);
        wait_done(lat);
        check_three("multi", lat);
    endtask

    task automatic test_stop();
        int lat;
        int saw_busy;
        kick(14'd3, 1'b0);
        while (cyc < 191) step();
        total++; if (tape_out !== 1'b1 || rd_addr !== 14'd1) begin
            bad++; $display("FAIL stop_pre tape=%b exp=1 addr=%0d exp=1", tape_out, rd_addr);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        total++; if (tape_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL stop_idle tape=%b busy=%b done=%b exp=000", tape_out, busy, done);
        end
        saw_busy = 0;
        repeat (300) begin step(); if (busy !== 1'b0) saw_busy++; end
        total++; if (done_cnt !== 0 || saw_busy !== 0) begin
            bad++; $display("FAIL stop_quiet done_cnt=%0d busy_cycles=%0d exp=0", done_cnt, saw_busy);
        end
        kick(14'd3, 1'b0);
        total++; if (rd_addr !== 14'd0) begin bad++; $display("FAIL stop_restart_addr got=%0d exp=0", rd_addr); end
        wait_done(lat);
        check_three("restart", lat);
    endtask

    task automatic test_busy_start_and_reset();
        int lat;
        ram[0] = 8'h80;
        kick(14'd1, 1'b0);
        while (cyc < 5) step();
        length = 14'd3; start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 30) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(lat);
        total++; if (lat !== 201) begin bad++; $display("FAIL busy_start_latency got=%0d exp=201", lat); end
        total++; if (bytes_q.size() !== 1 || high_cnt !== 74) begin
            bad++; $display("FAIL busy_start_bytes n=%0d exp=1 high=%0d exp=74", bytes_q.size(), high_cnt);
        end
        ram[0] = 8'h00; ram[1] = 8'hFF; ram[2] = 8'hA5;
        kick(14'd3, 1'b0);
        while (cyc < 220) step();
        total++; if (tape_out !== 1'b0 || busy !== 1'b1 || rd_addr !== 14'd1) begin
            bad++; $display("FAIL gap_pre tape=%b busy=%b addr=%0d exp=0,1,1", tape_out, busy, rd_addr);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (tape_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_addr !== 14'd0) begin
            bad++; $display("FAIL gap_reset tape=%b busy=%b done=%b addr=%0d exp=0,0,0,0", tape_out, busy, done, rd_addr);
        end
        repeat (20) step();
        kick(14'd3, 1'b0);
        wait_done(lat);
        check_three("post_reset", lat);
    endtask

    task automatic test_empty();
        int lat;
        kick(14'd0, 1'b0);
        wait_done(lat);
        total++; if (lat !== int'(L) + 1) begin bad++; $display("FAIL empty_latency got=%0d exp=%0d", lat, L + 1); end
        total++; if (high_cnt !== 0) begin bad++; $display("FAIL empty_high got=%0d exp=0", high_cnt); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL empty_done_count got=%0d exp=1", done_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        test_reset();
        test_single_byte();
        test_name_only();
        test_multi_byte();
        test_stop();
        test_busy_start_and_reset();
        test_empty();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
